pixel_dispatch_scheduler: RTL

- Walks a rectangular region of the complex plane in raster order and hands one c-coordinate per pixel to a bank of N_CORES Mandelbrot neuron cores over their pixel valid/ready handshake.
- Captures each core's one-cycle result pulse into a per-core holding register.
- Drains the holding registers round-robin into a single backpressured result stream for the framebuffer writer.
- Sits between the frame-control registers and the neuron array.

---
 rtl/pixel_dispatch_scheduler.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/pixel_dispatch_scheduler.sv
// rtl/pixel_dispatch_scheduler.sv - raster pixel dispatcher and round-robin result collector for neuron cores
module pixel_dispatch_scheduler #(
    parameter int N_CORES = 4,
    parameter int WIDTH   = 32,
    parameter int FRAC    = 28,
    parameter int ITER_W  = 16,
    parameter int DIM_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [WIDTH-1:0]         cfg_re0,
    input  logic [WIDTH-1:0]         cfg_im0,
    input  logic [WIDTH-1:0]         cfg_step,
    input  logic [DIM_W-1:0]         cfg_cols,
    input  logic [DIM_W-1:0]         cfg_rows,
    input  logic [ITER_W-1:0]        cfg_max_iter,
    output logic                     busy,
    output logic                     done,
    output logic [N_CORES-1:0]       core_valid,
    input  logic [N_CORES-1:0]       core_ready,
    output logic [WIDTH-1:0]         core_c_re,
    output logic [WIDTH-1:0]         core_c_im,
    output logic [15:0]              core_pixel_id,
    output logic [ITER_W-1:0]        core_max_iter,
    input  logic [N_CORES-1:0]       core_res_valid,
    input  logic [N_CORES*16-1:0]    core_res_pixel_id,
    input  logic [N_CORES*ITER_W-1:0] core_res_iter,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [15:0]              out_pixel_id,
    output logic [ITER_W-1:0]        out_iter
);

    localparam int PW = (N_CORES > 1) ? $clog2(N_CORES) : 1;
    localparam int OW = $clog2(N_CORES) + 2;

    if (N_CORES < 2 || N_CORES > 16 || FRAC >= WIDTH) begin : g_param_check
        $error("pixel_dispatch_scheduler: illegal parameter combination");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t              state, state_nx;
    logic [WIDTH-1:0]    re0_q, step_q, cur_re, cur_im;
    logic [DIM_W-1:0]    cols_q, rows_q, col, row;
    logic [15:0]         pix_id;
    logic [ITER_W-1:0]   max_iter_q;
    logic [PW-1:0]       rr_disp, rr_out, grant_idx, out_search, out_idx, lock_idx;
    logic [PW-1:0]       gi, oi;
    logic [OW-1:0]       outstanding;
    logic [N_CORES-1:0]  hold_full, eligible;
    logic [15:0]         hold_id   [N_CORES];
    logic [ITER_W-1:0]   hold_iter [N_CORES];
    logic                grant_any, found_out, dispatch, last_col, last_pix;
    logic                lock_valid, drain_fire;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] i);
        return (int'(i) == N_CORES - 1) ? '0 : i + 1'b1;
    endfunction

    // A core that was strobed last cycle still shows ready, so it is masked out.
    always_comb begin
        eligible   = core_ready & ~hold_full & ~core_valid;
        grant_any  = 1'b0;
        grant_idx  = rr_disp;
        found_out  = 1'b0;
        out_search = rr_out;
        gi         = rr_disp;
        oi         = rr_out;
        for (int i = 0; i < N_CORES; i++) begin
            if (!grant_any && eligible[gi]) begin
                grant_any = 1'b1;
                grant_idx = gi;
            end
            if (!found_out && hold_full[oi]) begin
                found_out  = 1'b1;
                out_search = oi;
            end
            gi = wrap_inc(gi);
            oi = wrap_inc(oi);
        end
    end

    // A stalled output keeps its slot even if a higher-priority slot fills meanwhile.
    assign out_idx      = lock_valid ? lock_idx : out_search;
    assign out_valid    = |hold_full;
    assign out_pixel_id = out_valid ? hold_id[out_idx] : '0;
    assign out_iter     = out_valid ? hold_iter[out_idx] : '0;
    assign drain_fire   = out_valid & out_ready;
    assign dispatch     = (state == S_RUN) && grant_any;
    assign last_col     = (col == cols_q - 1'b1);
    assign last_pix     = last_col && (row == rows_q - 1'b1);
    assign busy         = (state == S_RUN) || (state == S_DRAIN);
    assign done         = (state == S_DONE);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = (cfg_cols == '0 || cfg_rows == '0) ? S_DONE : S_RUN;
            S_RUN:   if (dispatch && last_pix) state_nx = S_DRAIN;
            S_DRAIN: if (outstanding == '0 && hold_full == '0) state_nx = S_DONE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            re0_q         <= '0;
            step_q        <= '0;
            cols_q        <= '0;
            rows_q        <= '0;
            max_iter_q    <= '0;
            cur_re        <= '0;
            cur_im        <= '0;
            col           <= '0;
            row           <= '0;
            pix_id        <= '0;
            rr_disp       <= '0;
            rr_out        <= '0;
            outstanding   <= '0;
            hold_full     <= '0;
            lock_valid    <= 1'b0;
            lock_idx      <= '0;
            core_valid    <= '0;
            core_c_re     <= '0;
            core_c_im     <= '0;
            core_pixel_id <= '0;
            core_max_iter <= '0;
        end else begin
            state      <= state_nx;
            core_valid <= '0;
            lock_valid <= out_valid & ~out_ready;
            lock_idx   <= out_idx;

            if (state == S_IDLE && start) begin
                re0_q      <= cfg_re0;
                step_q     <= cfg_step;
                cols_q     <= cfg_cols;
                rows_q     <= cfg_rows;
                max_iter_q <= cfg_max_iter;
                cur_re     <= cfg_re0;
                cur_im     <= cfg_im0;
                col        <= '0;
                row        <= '0;
                pix_id     <= '0;
            end

            if (dispatch) begin
                core_valid    <= N_CORES'(1) << grant_idx;
                core_c_re     <= cur_re;
                core_c_im     <= cur_im;
                core_pixel_id <= pix_id;
                core_max_iter <= max_iter_q;
                rr_disp       <= wrap_inc(grant_idx);
                pix_id        <= pix_id + 16'd1;
                if (last_col) begin
                    col    <= '0;
                    row    <= row + 1'b1;
                    cur_re <= re0_q;
                    cur_im <= cur_im - step_q;
                end else begin
                    col    <= col + 1'b1;
                    cur_re <= cur_re + step_q;
                end
            end

            if (drain_fire) rr_out <= wrap_inc(out_idx);

            case ({dispatch, drain_fire})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase

            for (int k = 0; k < N_CORES; k++) begin
                if (core_res_valid[k]) hold_full[k] <= 1'b1;
                else if (drain_fire && out_idx == PW'(k)) hold_full[k] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < N_CORES; k++) begin
            if (core_res_valid[k]) begin
                hold_id[k]   <= core_res_pixel_id[16*k +: 16];
                hold_iter[k] <= core_res_iter[ITER_W*k +: ITER_W];
            end
        end
    end

endmodule
